// File: rtl/seq_mul_shift.sv
// Radix-2 shift-add sequential multiplier with start/busy/done handshake.
// Signed operands are multiplied as magnitudes and the sign is applied to the final sum.
module seq_mul_shift #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, CALC} state_t;

    state_t             state;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc_next;

    // -2^(WIDTH-1) maps onto 2^(WIDTH-1), which still fits as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        logic signed [WIDTH-1:0] sv;
        sv = $signed(v);
        if (sgn && sv < 0)
            return WIDTH'(-sv);
        return v;
    endfunction

    // Negating zero yields zero, so no -0 artefact can appear.
    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    always_comb begin
        acc_next = acc;
        if (mag_b[0])
            acc_next = acc + ({{WIDTH{1'b0}}, mag_a} << cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_a <= magnitude(a_in, is_signed);
                        mag_b <= magnitude(b_in, is_signed);
                        neg   <= is_signed & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    mag_b <= mag_b >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        result <= apply_sign(acc_next, neg);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
